// File: rtl/rescale_ctrl_if.sv
// ----------------------------------------------------------------------------
// rescale_ctrl_if
//
// Purpose: bundles the pixel input stream, frame buffer read port and the
// rescale datapath control outputs of rescale_ctrl into one connection.
//
// Signals:
//   i_valid      pixel strobe, only honoured while o_ready is high
//   i_pixel      signed convolution result (NB_PIXEL bits)
//   i_last       marks the final pixel of the frame (qualified by i_valid)
//   o_ready      high while the controller is scanning a frame
//   o_maxByte    latched signed frame maximum
//   o_minByte    latched signed frame minimum
//   o_endSignal  one-cycle pulse when o_maxByte/o_minByte update
//   o_flat       latched (max == min)
//   o_rd_en      frame buffer read enable
//   o_rd_addr    frame buffer read address (0 when not reading)
//   o_pix_valid  read enable delayed by the frame buffer latency
//   o_busy       high while latching, reading or draining
//   o_done       one-cycle pulse after the last valid output pixel
//
// Modports:
//   master  the producer / consumer side (drives i_*, observes o_*)
//   slave   the controller side (observes i_*, drives o_*)
// ----------------------------------------------------------------------------
interface rescale_ctrl_if #(
    parameter int NB_PIXEL = 19,
    parameter int NB_ADDR  = 12
);
    logic                       i_valid;
    logic signed [NB_PIXEL-1:0] i_pixel;
    logic                       i_last;
    logic                       o_ready;
    logic signed [NB_PIXEL-1:0] o_maxByte;
    logic signed [NB_PIXEL-1:0] o_minByte;
    logic                       o_endSignal;
    logic                       o_flat;
    logic                       o_rd_en;
    logic        [NB_ADDR-1:0]  o_rd_addr;
    logic                       o_pix_valid;
    logic                       o_busy;
    logic                       o_done;

    modport master (
        output i_valid,
        output i_pixel,
        output i_last,
        input  o_ready,
        input  o_maxByte,
        input  o_minByte,
        input  o_endSignal,
        input  o_flat,
        input  o_rd_en,
        input  o_rd_addr,
        input  o_pix_valid,
        input  o_busy,
        input  o_done
    );

    modport slave (
        input  i_valid,
        input  i_pixel,
        input  i_last,
        output o_ready,
        output o_maxByte,
        output o_minByte,
        output o_endSignal,
        output o_flat,
        output o_rd_en,
        output o_rd_addr,
        output o_pix_valid,
        output o_busy,
        output o_done
    );
endinterface

// File: rtl/rescale_ctrl.sv
// ----------------------------------------------------------------------------
// rescale_ctrl
//
// Purpose: two-pass sequencer for the pixel rescaling datapath. The first
// pass scans a frame of signed convolution results and tracks the running
// signed minimum and maximum. At the end of the frame those extremes are
// latched for the rescale datapath (with a one-cycle end pulse). The second
// pass replays the frame from the external frame buffer with sequential read
// addresses and flags which datapath output cycles carry valid pixels.
//
// Parameters:
//   NB_PIXEL    signed pixel width
//   NB_ADDR     frame buffer address width
//   N_PIXELS    maximum frame length (<= 2**NB_ADDR)
//   RD_LATENCY  frame buffer read latency in cycles (>= 1)
//
// Ports:
//   i_clock  clock, rising edge
//   i_reset  asynchronous active-high reset
//   bus      rescale_ctrl_if.slave: pixel stream in, read port and
//            datapath controls out
// ----------------------------------------------------------------------------
module rescale_ctrl #(
    parameter int NB_PIXEL   = 19,
    parameter int NB_ADDR    = 12,
    parameter int N_PIXELS   = 4096,
    parameter int RD_LATENCY = 2
) (
    input  logic          i_clock,
    input  logic          i_reset,
    rescale_ctrl_if.slave bus
);

    // The pixel counter must be able to hold the full frame length, which can
    // be one more than the largest address.
    localparam int CNT_W = $clog2(N_PIXELS + 1);
    localparam int DRN_W = $clog2(RD_LATENCY + 1);

    localparam logic [CNT_W-1:0] LAST_IDX  = CNT_W'(N_PIXELS - 1);
    localparam logic [DRN_W-1:0] DRN_LAST  = DRN_W'(RD_LATENCY - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [DRN_W-1:0] DRN_ONE   = DRN_W'(1);
    localparam logic [NB_ADDR-1:0] ADDR_ONE = NB_ADDR'(1);

    typedef enum logic [1:0] {
        ST_SCAN,
        ST_LATCH,
        ST_READ,
        ST_DRAIN
    } state_t;

    state_t                     state;
    logic                       first;
    logic signed [NB_PIXEL-1:0] run_min;
    logic signed [NB_PIXEL-1:0] run_max;
    logic signed [NB_PIXEL-1:0] nxt_min;
    logic signed [NB_PIXEL-1:0] nxt_max;
    logic        [CNT_W-1:0]    count;
    logic        [CNT_W-1:0]    len;
    logic        [DRN_W-1:0]    drain_cnt;
    logic        [RD_LATENCY-1:0] pv_pipe;

    logic                       ready_q;
    logic signed [NB_PIXEL-1:0] max_q;
    logic signed [NB_PIXEL-1:0] min_q;
    logic                       end_q;
    logic                       flat_q;
    logic                       rd_en_q;
    logic        [NB_ADDR-1:0]  rd_addr_q;
    logic                       busy_q;
    logic                       done_q;

    logic accept;
    logic frame_end;
    logic rd_last;

    // ready_q is only ever high in SCAN, so it doubles as the state qualifier
    // for incoming pixels.
    assign accept    = bus.i_valid & ready_q;
    assign frame_end = accept & (bus.i_last | (count == LAST_IDX));
    assign rd_last   = (CNT_W'(rd_addr_q) == (len - CNT_ONE));

    // Running extremes including the pixel currently on the input, so that
    // the final pixel of a frame is folded in before the values are latched.
    always_comb begin
        nxt_max = run_max;
        nxt_min = run_min;
        if (first) begin
            nxt_max = bus.i_pixel;
            nxt_min = bus.i_pixel;
        end else begin
            if (bus.i_pixel > run_max) begin
                nxt_max = bus.i_pixel;
            end
            if (bus.i_pixel < run_min) begin
                nxt_min = bus.i_pixel;
            end
        end
    end

    // Sequencer. The latched extremes and the end pulse are registered on the
    // edge that leaves SCAN, so they are visible for the whole LATCH cycle
    // together with o_endSignal, one cycle after the last accepted pixel.
    // DRAIN lasts RD_LATENCY cycles; o_done is registered on its final edge
    // and so appears one cycle after the last o_pix_valid.
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            state     <= ST_SCAN;
            first     <= 1'b1;
            run_min   <= '0;
            run_max   <= '0;
            count     <= '0;
            len       <= '0;
            drain_cnt <= '0;
            ready_q   <= 1'b1;
            max_q     <= '0;
            min_q     <= '0;
            end_q     <= 1'b0;
            flat_q    <= 1'b0;
            rd_en_q   <= 1'b0;
            rd_addr_q <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            end_q  <= 1'b0;
            done_q <= 1'b0;
            case (state)
                ST_SCAN: begin
                    if (accept) begin
                        run_max <= nxt_max;
                        run_min <= nxt_min;
                        first   <= 1'b0;
                        count   <= count + CNT_ONE;
                        if (frame_end) begin
                            len     <= count + CNT_ONE;
                            max_q   <= nxt_max;
                            min_q   <= nxt_min;
                            flat_q  <= (nxt_max == nxt_min);
                            end_q   <= 1'b1;
                            ready_q <= 1'b0;
                            busy_q  <= 1'b1;
                            state   <= ST_LATCH;
                        end
                    end
                end
                ST_LATCH: begin
                    rd_en_q   <= 1'b1;
                    rd_addr_q <= '0;
                    state     <= ST_READ;
                end
                ST_READ: begin
                    if (rd_last) begin
                        rd_en_q   <= 1'b0;
                        rd_addr_q <= '0;
                        drain_cnt <= '0;
                        state     <= ST_DRAIN;
                    end else begin
                        rd_addr_q <= rd_addr_q + ADDR_ONE;
                    end
                end
                ST_DRAIN: begin
                    if (drain_cnt == DRN_LAST) begin
                        done_q  <= 1'b1;
                        ready_q <= 1'b1;
                        busy_q  <= 1'b0;
                        first   <= 1'b1;
                        count   <= '0;
                        state   <= ST_SCAN;
                    end else begin
                        drain_cnt <= drain_cnt + DRN_ONE;
                    end
                end
                default: begin
                    state <= ST_SCAN;
                end
            endcase
        end
    end

    // Delay line matching the frame buffer latency; its tail marks the cycles
    // in which read data reaches the datapath.
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            pv_pipe <= '0;
        end else begin
            pv_pipe[0] <= rd_en_q;
            for (int i = 1; i < RD_LATENCY; i++) begin
                pv_pipe[i] <= pv_pipe[i-1];
            end
        end
    end

    assign bus.o_ready     = ready_q;
    assign bus.o_maxByte   = max_q;
    assign bus.o_minByte   = min_q;
    assign bus.o_endSignal = end_q;
    assign bus.o_flat      = flat_q;
    assign bus.o_rd_en     = rd_en_q;
    assign bus.o_rd_addr   = rd_addr_q;
    assign bus.o_pix_valid = pv_pipe[RD_LATENCY-1];
    assign bus.o_busy      = busy_q;
    assign bus.o_done      = done_q;

endmodule

// File: tb/tb_rescale_ctrl.sv
// ----------------------------------------------------------------------------
// tb_rescale_ctrl
//
// Purpose: self-checking bench for rescale_ctrl. Frames are described as a
// list of (pixel, valid, last) input cycles; a frame model derives the
// accepted pixels, their extremes, the frame length and the cycle of the last
// accepted pixel, from which the expected output timeline follows.
// ----------------------------------------------------------------------------
module tb_rescale_ctrl;

    localparam int NB_PIXEL   = 19;
    localparam int NB_ADDR    = 12;
    localparam int N_PIXELS   = 8;
    localparam int RD_LATENCY = 2;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    rescale_ctrl_if #(.NB_PIXEL(NB_PIXEL), .NB_ADDR(NB_ADDR)) bus ();

    rescale_ctrl #(
        .NB_PIXEL  (NB_PIXEL),
        .NB_ADDR   (NB_ADDR),
        .N_PIXELS  (N_PIXELS),
        .RD_LATENCY(RD_LATENCY)
    ) dut (
        .i_clock(clk),
        .i_reset(rst),
        .bus    (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Event log, sampled shortly after each rising edge and labelled with the
    // cycle number of that edge.
    int end_cyc[$];
    int rd_cyc[$];
    int rd_addr[$];
    int pv_cyc[$];
    int done_cyc[$];
    int mx_cyc[$];
    int addr_idle_bad = 0;
    logic signed [NB_PIXEL-1:0] prev_max;
    logic signed [NB_PIXEL-1:0] prev_min;

    always @(posedge clk) begin
        #2;
        if (bus.o_endSignal) end_cyc.push_back(cyc);
        if (bus.o_rd_en) begin
            rd_cyc.push_back(cyc);
            rd_addr.push_back(int'(bus.o_rd_addr));
        end else if (bus.o_rd_addr != '0) begin
            addr_idle_bad++;
        end
        if (bus.o_pix_valid) pv_cyc.push_back(cyc);
        if (bus.o_done) done_cyc.push_back(cyc);
        if (bus.o_maxByte !== prev_max || bus.o_minByte !== prev_min) mx_cyc.push_back(cyc);
        prev_max = bus.o_maxByte;
        prev_min = bus.o_minByte;
    end

    // Stimulus description and frame model state
    int st_pix[$];
    bit st_val[$];
    bit st_last[$];
    int acc_q[$];
    bit rdy_seen[$];
    int t_last;
    bit ended;

    task automatic clear_mon();
        end_cyc.delete();
        rd_cyc.delete();
        rd_addr.delete();
        pv_cyc.delete();
        done_cyc.delete();
        mx_cyc.delete();
        addr_idle_bad = 0;
    endtask

    task automatic push_stim(input int p, input bit v, input bit l);
        st_pix.push_back(p);
        st_val.push_back(v);
        st_last.push_back(l);
    endtask

    function automatic int rand_pix();
        logic signed [NB_PIXEL-1:0] v;
        v = NB_PIXEL'($urandom);
        return int'(v);
    endfunction

    // Drives the stimulus list one cycle per entry. The model accepts a valid
    // pixel until the frame has ended, by i_last or by reaching N_PIXELS.
    task automatic drive_stim();
        acc_q.delete();
        rdy_seen.delete();
        ended  = 1'b0;
        t_last = -1;
        for (int i = 0; i < st_pix.size(); i++) begin
            @(negedge clk);
            rdy_seen.push_back(bus.o_ready);
            bus.i_valid = st_val[i];
            bus.i_pixel = NB_PIXEL'(st_pix[i]);
            bus.i_last  = st_last[i];
            if (st_val[i] && !ended) begin
                acc_q.push_back(st_pix[i]);
                if (st_last[i] || acc_q.size() == N_PIXELS) begin
                    ended  = 1'b1;
                    t_last = cyc;
                end
            end
        end
        @(negedge clk);
        bus.i_valid = 1'b0;
        bus.i_last  = 1'b0;
        bus.i_pixel = '0;
        st_pix.delete();
        st_val.delete();
        st_last.delete();
    endtask

    task automatic model_frame(output int mx, output int mn);
        mx = 0;
        mn = 0;
        if (acc_q.size() > 0) begin
            mx = acc_q[0];
            mn = acc_q[0];
        end
        foreach (acc_q[i]) begin
            if (acc_q[i] > mx) mx = acc_q[i];
            if (acc_q[i] < mn) mn = acc_q[i];
        end
    endtask

    task automatic wait_done(input int budget, output bit to);
        for (int k = 0; k < budget; k++) begin
            @(negedge clk);
            if (done_cyc.size() > 0) break;
        end
        to = (done_cyc.size() == 0);
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.i_valid = 1'b0;
        bus.i_pixel = '0;
        bus.i_last  = 1'b0;
        repeat (3) @(negedge clk);
        n_tests++;
        if (bus.o_ready !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL reset ready: got %b expected 1", bus.o_ready);
        end
        n_tests++;
        if ({bus.o_busy, bus.o_rd_en, bus.o_endSignal, bus.o_done, bus.o_pix_valid, bus.o_flat} !== 6'b0) begin
            n_fail++;
            $display("[TB] FAIL reset flags: got %b expected 000000",
                     {bus.o_busy, bus.o_rd_en, bus.o_endSignal, bus.o_done, bus.o_pix_valid, bus.o_flat});
        end
        n_tests++;
        if (bus.o_maxByte !== '0 || bus.o_minByte !== '0 || bus.o_rd_addr !== '0) begin
            n_fail++;
            $display("[TB] FAIL reset values: got max %0d min %0d addr %0d expected 0 0 0",
                     bus.o_maxByte, bus.o_minByte, bus.o_rd_addr);
        end
        rst = 1'b0;
        repeat (2) @(negedge clk);
        n_tests++;
        if (bus.o_ready !== 1'b1 || bus.o_busy !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL idle after reset: got ready %b busy %b expected 1 0", bus.o_ready, bus.o_busy);
        end
    endtask

    task automatic test_basic_frame();
        int mx, mn, len, bad;
        bit to;
        clear_mon();
        push_stim(5, 1, 0);
        push_stim(-3, 1, 0);
        push_stim(12, 1, 0);
        push_stim(0, 1, 1);
        drive_stim();
        wait_done(60, to);
        model_frame(mx, mn);
        len = acc_q.size();
        n_tests++;
        if (to) begin
            n_fail++;
            $display("[TB] FAIL basic timeout: got no done expected done");
        end
        n_tests++;
        if (int'(bus.o_maxByte) !== mx || int'(bus.o_minByte) !== mn || bus.o_flat !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL basic extremes: got %0d/%0d flat %b expected %0d/%0d flat 0",
                     bus.o_maxByte, bus.o_minByte, bus.o_flat, mx, mn);
        end
        n_tests++;
        if (end_cyc.size() != 1 || end_cyc[0] != t_last + 1) begin
            n_fail++;
            $display("[TB] FAIL basic end pulse: got %0d pulses first at %0d expected 1 at %0d",
                     end_cyc.size(), (end_cyc.size() > 0) ? end_cyc[0] : -1, t_last + 1);
        end
        bad = 0;
        for (int i = 0; i < rd_cyc.size(); i++) begin
            if (rd_addr[i] != i || rd_cyc[i] != t_last + 2 + i) bad++;
        end
        n_tests++;
        if (rd_cyc.size() != len || bad != 0) begin
            n_fail++;
            $display("[TB] FAIL basic reads: got %0d reads %0d bad expected %0d reads 0 bad",
                     rd_cyc.size(), bad, len);
        end
        n_tests++;
        if (pv_cyc.size() != len || pv_cyc[0] != t_last + 2 + RD_LATENCY) begin
            n_fail++;
            $display("[TB] FAIL basic pix_valid: got %0d cycles first at %0d expected %0d first at %0d",
                     pv_cyc.size(), (pv_cyc.size() > 0) ? pv_cyc[0] : -1, len, t_last + 2 + RD_LATENCY);
        end
        n_tests++;
        if (done_cyc.size() != 1 || done_cyc[0] != t_last + 2 + len + RD_LATENCY) begin
            n_fail++;
            $display("[TB] FAIL basic done: got %0d at %0d expected 1 at %0d",
                     done_cyc.size(), (done_cyc.size() > 0) ? done_cyc[0] : -1, t_last + 2 + len + RD_LATENCY);
        end
        n_tests++;
        if (addr_idle_bad != 0) begin
            n_fail++;
            $display("[TB] FAIL basic idle addr: got %0d nonzero cycles expected 0", addr_idle_bad);
        end
    endtask

    task automatic test_single_pixel();
        bit to;
        clear_mon();
        push_stim(-7, 1, 1);
        drive_stim();
        wait_done(40, to);
        n_tests++;
        if (to || int'(bus.o_maxByte) !== -7 || int'(bus.o_minByte) !== -7 || bus.o_flat !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL single extremes: got %0d/%0d flat %b timeout %b expected -7/-7 flat 1 timeout 0",
                     bus.o_maxByte, bus.o_minByte, bus.o_flat, to);
        end
        n_tests++;
        if (rd_cyc.size() != 1 || rd_addr[0] != 0 || pv_cyc.size() != 1) begin
            n_fail++;
            $display("[TB] FAIL single reads: got %0d reads %0d valids expected 1 1", rd_cyc.size(), pv_cyc.size());
        end
        n_tests++;
        if (done_cyc.size() != 1 || done_cyc[0] != t_last + 3 + RD_LATENCY) begin
            n_fail++;
            $display("[TB] FAIL single done: got %0d at %0d expected 1 at %0d",
                     done_cyc.size(), (done_cyc.size() > 0) ? done_cyc[0] : -1, t_last + 3 + RD_LATENCY);
        end
    endtask

    task automatic test_forced_end();
        int mx, mn, bad;
        bit to;
        clear_mon();
        for (int i = 0; i < N_PIXELS; i++) push_stim(int'($urandom_range(0, 2000)) - 1000, 1, 0);
        push_stim(200000, 1, 1);
        drive_stim();
        wait_done(60, to);
        model_frame(mx, mn);
        n_tests++;
        if (rdy_seen[N_PIXELS] !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL forced ready after end: got %b expected 0", rdy_seen[N_PIXELS]);
        end
        n_tests++;
        if (to || int'(bus.o_maxByte) !== mx || int'(bus.o_minByte) !== mn) begin
            n_fail++;
            $display("[TB] FAIL forced extremes: got %0d/%0d expected %0d/%0d", bus.o_maxByte, bus.o_minByte, mx, mn);
        end
        bad = 0;
        for (int i = 0; i < rd_addr.size(); i++) if (rd_addr[i] != i) bad++;
        n_tests++;
        if (rd_cyc.size() != N_PIXELS || bad != 0 || end_cyc.size() != 1 || end_cyc[0] != t_last + 1) begin
            n_fail++;
            $display("[TB] FAIL forced reads: got %0d reads %0d bad %0d ends expected %0d reads 0 bad 1 end",
                     rd_cyc.size(), bad, end_cyc.size(), N_PIXELS);
        end
    endtask

    task automatic test_extremes();
        bit to;
        int t_b;
        clear_mon();
        push_stim(-262144, 1, 0);
        push_stim(262143, 1, 1);
        drive_stim();
        wait_done(40, to);
        n_tests++;
        if (to || int'(bus.o_maxByte) !== 262143 || int'(bus.o_minByte) !== -262144 || bus.o_flat !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL extremes: got %0d/%0d flat %b expected 262143/-262144 flat 0",
                     bus.o_maxByte, bus.o_minByte, bus.o_flat);
        end
        clear_mon();
        push_stim(1, 1, 0);
        push_stim(1, 1, 0);
        push_stim(1, 1, 1);
        drive_stim();
        t_b = t_last;
        wait_done(40, to);
        n_tests++;
        if (mx_cyc.size() != 1 || mx_cyc[0] != t_b + 1) begin
            n_fail++;
            $display("[TB] FAIL extremes hold: got %0d changes first at %0d expected 1 at %0d",
                     mx_cyc.size(), (mx_cyc.size() > 0) ? mx_cyc[0] : -1, t_b + 1);
        end
        n_tests++;
        if (to || int'(bus.o_maxByte) !== 1 || int'(bus.o_minByte) !== 1 || bus.o_flat !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL flat frame: got %0d/%0d flat %b expected 1/1 flat 1",
                     bus.o_maxByte, bus.o_minByte, bus.o_flat);
        end
    endtask

    task automatic test_gapped();
        int mx, mn;
        bit to;
        clear_mon();
        for (int i = 0; i < 4; i++) begin
            push_stim(int'($urandom_range(0, 2000)) - 1000, 1, (i == 3));
            if (i < 3) push_stim(200000, 0, 1);
        end
        drive_stim();
        // Keep offering large pixels while the controller is busy.
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            bus.i_valid = bus.o_busy;
            bus.i_pixel = NB_PIXEL'((k % 2 == 0) ? 200000 : -200000);
            bus.i_last  = k[0];
            if (done_cyc.size() > 0) break;
        end
        bus.i_valid = 1'b0;
        bus.i_last  = 1'b0;
        to = (done_cyc.size() == 0);
        model_frame(mx, mn);
        repeat (3) @(negedge clk);
        n_tests++;
        if (to || int'(bus.o_maxByte) !== mx || int'(bus.o_minByte) !== mn) begin
            n_fail++;
            $display("[TB] FAIL gapped extremes: got %0d/%0d expected %0d/%0d", bus.o_maxByte, bus.o_minByte, mx, mn);
        end
        n_tests++;
        if (rd_cyc.size() != 4 || pv_cyc.size() != 4) begin
            n_fail++;
            $display("[TB] FAIL gapped length: got %0d reads %0d valids expected 4 4", rd_cyc.size(), pv_cyc.size());
        end
        n_tests++;
        if (bus.o_busy !== 1'b0 || end_cyc.size() != 1) begin
            n_fail++;
            $display("[TB] FAIL gapped stray frame: got busy %b ends %0d expected 0 1", bus.o_busy, end_cyc.size());
        end
    endtask

    task automatic test_reset_mid_read();
        bit found, to;
        clear_mon();
        for (int i = 0; i < 4; i++) push_stim(10 * i + 3, 1, (i == 3));
        drive_stim();
        found = 1'b0;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            if (bus.o_rd_en && bus.o_rd_addr == NB_ADDR'(2)) begin
                found = 1'b1;
                break;
            end
        end
        n_tests++;
        if (!found) begin
            n_fail++;
            $display("[TB] FAIL midread reach addr 2: got not reached expected reached");
        end
        rst = 1'b1;
        #1;
        n_tests++;
        if (bus.o_rd_en !== 1'b0 || bus.o_busy !== 1'b0 || bus.o_ready !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL midread flags: got rd_en %b busy %b ready %b expected 0 0 1",
                     bus.o_rd_en, bus.o_busy, bus.o_ready);
        end
        n_tests++;
        if (bus.o_maxByte !== '0 || bus.o_minByte !== '0) begin
            n_fail++;
            $display("[TB] FAIL midread extremes: got %0d/%0d expected 0/0", bus.o_maxByte, bus.o_minByte);
        end
        @(negedge clk);
        rst = 1'b0;
        clear_mon();
        repeat (10) @(negedge clk);
        n_tests++;
        if (pv_cyc.size() != 0 || done_cyc.size() != 0 || rd_cyc.size() != 0) begin
            n_fail++;
            $display("[TB] FAIL midread aftermath: got %0d valids %0d dones %0d reads expected 0 0 0",
                     pv_cyc.size(), done_cyc.size(), rd_cyc.size());
        end
        clear_mon();
        push_stim(3, 1, 0);
        push_stim(-1, 1, 1);
        drive_stim();
        wait_done(40, to);
        n_tests++;
        if (to || int'(bus.o_maxByte) !== 3 || int'(bus.o_minByte) !== -1 || rd_cyc.size() != 2 ||
            done_cyc[0] != t_last + 4 + RD_LATENCY) begin
            n_fail++;
            $display("[TB] FAIL midread next frame: got %0d/%0d reads %0d timeout %b expected 3/-1 reads 2 timeout 0",
                     bus.o_maxByte, bus.o_minByte, rd_cyc.size(), to);
        end
    endtask

    task automatic test_random();
        int mx, mn, len, bad, target;
        bit forced, to;
        for (int f = 0; f < 20; f++) begin
            clear_mon();
            target = int'($urandom_range(1, N_PIXELS));
            forced = (target == N_PIXELS) && ($urandom_range(0, 1) == 1);
            for (int a = 0; a < target; a++) begin
                repeat ($urandom_range(0, 2)) push_stim(rand_pix(), 0, 1'($urandom_range(0, 1)));
                push_stim(rand_pix(), 1, (a == target - 1) && !forced);
            end
            if (forced) push_stim(rand_pix(), 1, 1);
            drive_stim();
            wait_done(80, to);
            model_frame(mx, mn);
            len = acc_q.size();
            n_tests++;
            if (to || int'(bus.o_maxByte) !== mx || int'(bus.o_minByte) !== mn || bus.o_flat !== (mx == mn)) begin
                n_fail++;
                $display("[TB] FAIL random %0d extremes: got %0d/%0d flat %b expected %0d/%0d flat %b",
                         f, bus.o_maxByte, bus.o_minByte, bus.o_flat, mx, mn, (mx == mn));
            end
            n_tests++;
            if (end_cyc.size() != 1 || end_cyc[0] != t_last + 1) begin
                n_fail++;
                $display("[TB] FAIL random %0d end pulse: got %0d pulses expected 1 at %0d", f, end_cyc.size(), t_last + 1);
            end
            bad = 0;
            for (int i = 0; i < rd_cyc.size(); i++) begin
                if (rd_addr[i] != i || rd_cyc[i] != t_last + 2 + i) bad++;
            end
            n_tests++;
            if (rd_cyc.size() != len || bad != 0) begin
                n_fail++;
                $display("[TB] FAIL random %0d reads: got %0d reads %0d bad expected %0d reads 0 bad",
                         f, rd_cyc.size(), bad, len);
            end
            n_tests++;
            if (pv_cyc.size() != len || pv_cyc[0] != t_last + 2 + RD_LATENCY) begin
                n_fail++;
                $display("[TB] FAIL random %0d pix_valid: got %0d cycles expected %0d from %0d",
                         f, pv_cyc.size(), len, t_last + 2 + RD_LATENCY);
            end
            n_tests++;
            if (done_cyc.size() != 1 || done_cyc[0] != t_last + 2 + len + RD_LATENCY || addr_idle_bad != 0) begin
                n_fail++;
                $display("[TB] FAIL random %0d done: got %0d at %0d idle-addr %0d expected 1 at %0d idle-addr 0",
                         f, done_cyc.size(), (done_cyc.size() > 0) ? done_cyc[0] : -1, addr_idle_bad,
                         t_last + 2 + len + RD_LATENCY);
            end
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got no finish expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        test_reset();
        test_basic_frame();
        test_single_pixel();
        test_forced_end();
        test_extremes();
        test_gapped();
        test_reset_mid_read();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/rescale_ctrl.md
Name: rescale_ctrl

Overview:
- Two-pass sequencer for the pixel rescaling datapath that maps signed convolution results to the 0..255 byte range.
- Pass 1 (SCAN): accepts a frame of signed NB_PIXEL-bit results and tracks the running signed min and max.
- At end of frame it latches max/min and pulses the end signal to the rescale datapath.
- Pass 2 (READ): replays the frame from the external frame buffer by issuing sequential read addresses, and marks which datapath output cycles are valid.

Parameters:
- NB_PIXEL, 19, signed pixel width; matches the rescale datapath.
- NB_ADDR, 12, frame buffer address width.
- N_PIXELS, 4096, maximum frame length; must be <= 2**NB_ADDR.
- RD_LATENCY, 2, frame buffer read latency in cycles; must be >= 1.

Ports:
- i_clock  in  1  clock; all logic on the rising edge.
- i_reset  in  1  asynchronous, active-high reset.
- i_valid  in  1  pixel strobe during SCAN.
- i_pixel  in  NB_PIXEL (signed)  convolution result.
- i_last  in  1  qualifies i_valid; marks the final pixel of the frame.
- o_ready  out  1  high only in SCAN; i_valid is ignored when low.
- o_maxByte  out  NB_PIXEL (signed)  latched frame maximum; drives the datapath maxByte.
- o_minByte  out  NB_PIXEL (signed)  latched frame minimum; drives the datapath minByte.
- o_endSignal  out  1  one-cycle pulse when o_maxByte/o_minByte update; drives the datapath i_endSignal.
- o_flat  out  1  latched (max == min); downstream forces the output to NEW_MIN.
- o_rd_en  out  1  frame buffer read enable.
- o_rd_addr  out  NB_ADDR  frame buffer read address.
- o_pix_valid  out  1  o_rd_en delayed by RD_LATENCY; qualifies the rescaled output.
- o_busy  out  1  high in LATCH, READ and DRAIN.
- o_done  out  1  one-cycle pulse when the frame is fully replayed.

Behaviour:
- Reset values: state SCAN, first flag set; all outputs 0 except o_ready=1. Reset is asynchronous and may assert in any state; it abandons the frame, clears the delay line and clears the latched min/max.
- States: SCAN -> LATCH -> READ -> DRAIN -> SCAN.
- SCAN, accepted pixel = i_valid & o_ready:
  - First accepted pixel of the frame loads run_min = run_max = i_pixel and clears the first flag.
  - Later pixels: signed compare; run_max takes i_pixel if greater, run_min takes i_pixel if smaller; ties leave the value unchanged.
  - Pixel counter increments on every accepted pixel.
  - End of frame: accepted pixel with i_last=1, or the accepted pixel with count == N_PIXELS-1 (forced end; i_last ignored). Either case stores len = count+1 and goes to LATCH.
  - The min/max update for the last pixel happens in that same cycle.
- LATCH (1 cycle):
  - o_maxByte <= run_max, o_minByte <= run_min, o_flat <= (run_max == run_min).
  - o_endSignal = 1 for exactly this cycle; goes to READ.
- READ:
  - o_rd_en = 1; o_rd_addr runs 0..len-1, one address per cycle, no gaps.
  - After address len-1 is issued, goes to DRAIN.
- DRAIN:
  - o_rd_en = 0; waits RD_LATENCY cycles.
  - o_done pulses in the cycle after the last o_pix_valid.
  - Then to SCAN: first flag set, counter cleared.
- o_pix_valid is an RD_LATENCY-deep shift register of o_rd_en. Total high cycles per frame = len.
- o_maxByte, o_minByte and o_flat hold their value until the next LATCH; they stay stable during READ and DRAIN and through the next SCAN.
- Cycle latency:
  - Last pixel accepted at cycle t -> o_endSignal at t+1.
  - First o_rd_en at t+2.
  - First o_pix_valid at t+2+RD_LATENCY.
  - o_done at t+2+len+RD_LATENCY.
- No backpressure in READ; the downstream consumer must take one pixel per cycle.
- o_rd_addr holds at 0 whenever o_rd_en = 0.

Test Plan:
- Frame {5, -3, 12, 0} with i_last on 0 -> o_maxByte=12, o_minByte=-3, o_flat=0. o_endSignal is one pulse, 1 cycle after the last pixel. Addresses 0,1,2,3 on consecutive cycles. o_pix_valid high 4 cycles, starting RD_LATENCY after the first read. o_done follows.
- Single-pixel frame {-7, i_last=1} -> max = min = -7, o_flat=1, len=1, one read at address 0, one o_pix_valid.
- N_PIXELS=8, 8 pixels with no i_last -> forced end after the 8th pixel; a 9th i_valid (o_ready=0) is ignored; 8 reads issued.
- Extremes {-262144, 262143} (NB_PIXEL=19) -> signed min/max correct, no overflow. Then a second frame {1, 1, 1} -> o_maxByte/o_minByte change only at the second LATCH; o_flat=1.
- Gapped input: i_valid toggles 1,0,1,0; i_valid asserted during READ/DRAIN -> only SCAN-cycle pixels counted; values in other states ignored.
- Reset asserted mid-READ at address 2 of 4 -> same cycle: o_rd_en=0, o_busy=0, o_ready=1, latched min/max = 0. No o_pix_valid or o_done afterwards. The next frame starts cleanly.
